// File: rtl/omok_win_checker_if.sv
// Request/response bundle between the game controller and omok_win_checker.
//   master (controller): drives board_state, check, pos; observes busy, done, win, winner.
//   slave  (checker)   : observes board_state, check, pos; drives busy, done, win, winner.
interface omok_win_checker_if #(
    parameter int unsigned MAP_N = 10
);
    localparam int unsigned BW = 2 * MAP_N * MAP_N;

    logic [BW-1:0] board_state;
    logic          check;
    logic [7:0]    pos;
    logic          busy;
    logic          done;
    logic          win;
    logic [1:0]    winner;

    modport master (
        output board_state, check, pos,
        input  busy, done, win, winner
    );

    modport slave (
        input  board_state, check, pos,
        output busy, done, win, winner
    );
endinterface

// File: rtl/omok_win_checker.sv
// Omok (gomoku) win detector. On a check request it snapshots the board,
// then walks outward from the placed stone one cell per cycle in each of the
// four line directions and reports whether a run of WIN_LEN or more exists.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of omok_win_checker_if (board/check/pos in,
//              busy/done/win/winner out; win/winner are sticky until reset)
module omok_win_checker #(
    parameter int unsigned MAP_N   = 10,
    parameter int unsigned WIN_LEN = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    omok_win_checker_if.slave    bus
);
    localparam int unsigned CELLS = MAP_N * MAP_N;
    localparam int unsigned BW    = 2 * CELLS;
    localparam int unsigned RW    = $clog2(MAP_N) + 2;  // signed coord, room for -1 and MAP_N
    localparam int unsigned CW    = 4;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_PROBE_POS = 3'd2;
    localparam logic [2:0] S_PROBE_NEG = 3'd3;
    localparam logic [2:0] S_EVAL      = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    localparam logic signed [RW-1:0] N_S     = RW'(MAP_N);
    localparam logic [CW-1:0]        CAP     = CW'(WIN_LEN - 1);
    localparam logic [CW-1:0]        WIN_RUN = CW'(WIN_LEN);

    logic [2:0]              state_q, state_d;
    logic [BW-1:0]           snap_q, snap_d;
    logic [7:0]              pos_q, pos_d;
    logic [1:0]              color_q, color_d;
    logic signed [RW-1:0]    org_row_q, org_row_d, org_col_q, org_col_d;
    logic signed [RW-1:0]    cur_row_q, cur_row_d, cur_col_q, cur_col_d;
    logic [1:0]              dir_q, dir_d;
    logic [CW-1:0]           run_q, run_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    win_q, win_d;
    logic [1:0]              winner_q, winner_d;

    logic signed [RW-1:0]    d_row, d_col, nxt_row, nxt_col;
    logic                    in_bounds;
    logic [7:0]              cell_idx;
    logic [1:0]              cell_c, load_c;
    logic                    probe_match;
    logic                    probe_end;
    logic                    pos_bad;

    // Next probe cell and whether it extends the current run.
    always_comb begin
        d_row = (dir_q == 2'd0) ? RW'(0) : RW'(1);
        case (dir_q)
            2'd0:    d_col = RW'(1);
            2'd1:    d_col = RW'(0);
            2'd2:    d_col = RW'(1);
            default: d_col = RW'(-1);
        endcase
        if (state_q == S_PROBE_NEG) begin
            nxt_row = cur_row_q - d_row;
            nxt_col = cur_col_q - d_col;
        end else begin
            nxt_row = cur_row_q + d_row;
            nxt_col = cur_col_q + d_col;
        end
        in_bounds   = !nxt_row[RW-1] && (nxt_row < N_S) && !nxt_col[RW-1] && (nxt_col < N_S);
        cell_idx    = in_bounds ? (8'(nxt_row) * 8'(MAP_N) + 8'(nxt_col)) : 8'd0;
        cell_c      = 2'(snap_q >> {cell_idx, 1'b0});
        probe_match = in_bounds && (cell_c == color_q);
        probe_end   = !probe_match || ((cnt_q + CW'(1)) == CAP);
        pos_bad     = ({1'b0, pos_q} >= 9'(CELLS));
        load_c      = pos_bad ? 2'b00 : 2'(snap_q >> {pos_q, 1'b0});
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        pos_d     = pos_q;
        color_d   = color_q;
        org_row_d = org_row_q;
        org_col_d = org_col_q;
        cur_row_d = cur_row_q;
        cur_col_d = cur_col_q;
        dir_d     = dir_q;
        run_d     = run_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        winner_d  = winner_q;

        case (state_q)
            S_IDLE: begin
                if (bus.check) begin
                    snap_d  = bus.board_state;
                    pos_d   = bus.pos;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // 00 and 01 are both empty: only codes with bit 1 set are stones.
                if (pos_bad || !load_c[1]) begin
                    state_d = S_DONE;
                end else begin
                    color_d   = load_c;
                    org_row_d = RW'(pos_q / 8'(MAP_N));
                    org_col_d = RW'(pos_q % 8'(MAP_N));
                    cur_row_d = RW'(pos_q / 8'(MAP_N));
                    cur_col_d = RW'(pos_q % 8'(MAP_N));
                    dir_d     = 2'd0;
                    run_d     = CW'(1);
                    cnt_d     = '0;
                    state_d   = S_PROBE_POS;
                end
            end
            S_PROBE_POS, S_PROBE_NEG: begin
                if (probe_match) begin
                    run_d     = run_q + CW'(1);
                    cnt_d     = cnt_q + CW'(1);
                    cur_row_d = nxt_row;
                    cur_col_d = nxt_col;
                end
                if (probe_end) begin
                    if (state_q == S_PROBE_POS) begin
                        cur_row_d = org_row_q;
                        cur_col_d = org_col_q;
                        cnt_d     = '0;
                        state_d   = S_PROBE_NEG;
                    end else begin
                        state_d = S_EVAL;
                    end
                end
            end
            S_EVAL: begin
                if (run_q >= WIN_RUN) begin
                    // An earlier win is kept; later winners are not recorded.
                    if (!win_q) begin
                        win_d    = 1'b1;
                        winner_d = color_q;
                    end
                    state_d = S_DONE;
                end else if (dir_q == 2'd3) begin
                    state_d = S_DONE;
                end else begin
                    dir_d     = dir_q + 2'd1;
                    run_d     = CW'(1);
                    cnt_d     = '0;
                    cur_row_d = org_row_q;
                    cur_col_d = org_col_q;
                    state_d   = S_PROBE_POS;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            snap_q    <= '0;
            pos_q     <= '0;
            color_q   <= '0;
            org_row_q <= '0;
            org_col_q <= '0;
            cur_row_q <= '0;
            cur_col_q <= '0;
            dir_q     <= '0;
            run_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            win_q     <= 1'b0;
            winner_q  <= 2'b00;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            pos_q     <= pos_d;
            color_q   <= color_d;
            org_row_q <= org_row_d;
            org_col_q <= org_col_d;
            cur_row_q <= cur_row_d;
            cur_col_q <= cur_col_d;
            dir_q     <= dir_d;
            run_q     <= run_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            win_q     <= win_d;
            winner_q  <= winner_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.win    = win_q;
    assign bus.winner = winner_q;
endmodule

// File: tb/tb_omok_win_checker.sv
// Directed bench for omok_win_checker: stimulus pushes expected results
// (latency, win, winner) into a scoreboard; a monitor pops on each done.
module tb_omok_win_checker;
    localparam int unsigned MAP_N = 10;
    localparam int unsigned BW    = 2 * MAP_N * MAP_N;

    typedef struct {
        int         lat;
        logic       win;
        logic [1:0] winner;
        int         acc;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic [BW-1:0] brd;

    omok_win_checker_if #(.MAP_N(MAP_N)) bus ();

    omok_win_checker #(.MAP_N(MAP_N), .WIN_LEN(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clr_board();
        brd = '0;
    endtask

    task automatic put(input int k, input logic [1:0] c);
        brd = (brd & ~(BW'(3) << (2 * k))) | (BW'(c) << (2 * k));
    endtask

    // Pulse check for one cycle and queue the expected result.
    task automatic issue(input int p, input int lat, input logic w, input logic [1:0] wn, input string nm);
        exp_t e;
        @(negedge clk);
        bus.board_state = brd;
        bus.pos         = 8'(p);
        bus.check       = 1'b1;
        @(negedge clk);
        bus.check = 1'b0;
        e.lat = lat; e.win = w; e.winner = wn; e.acc = cyc; e.name = nm;
        sb.push_back(e);
        chk({nm, " busy_after_accept"}, int'(bus.busy), 1);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk({nm, " done_timeout"}, 0, 1);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, " latency"}, cyc - e.acc, e.lat);
                chk({e.name, " win"}, int'(bus.win), int'(e.win));
                chk({e.name, " winner"}, int'(bus.winner), int'(e.winner));
                chk({e.name, " busy_in_done"}, int'(bus.busy), 0);
            end
        end
    end

    initial begin
        bus.board_state = '0;
        bus.pos         = '0;
        bus.check       = 1'b0;
        clr_board();
        repeat (3) @(negedge clk);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset done", int'(bus.done), 0);
        chk("reset win", int'(bus.win), 0);
        chk("reset winner", int'(bus.winner), 0);
        rst = 1'b0;

        // Mid-scan reset: re-check ignored, abort without done.
        clr_board(); put(44, 2'b10);
        @(negedge clk);
        bus.board_state = brd; bus.pos = 8'd44; bus.check = 1'b1;
        @(negedge clk);
        bus.check = 1'b0;
        repeat (2) @(negedge clk);
        bus.check = 1'b1;
        @(negedge clk);
        bus.check = 1'b0;
        chk("abort busy_before_rst", int'(bus.busy), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort busy_on_rst", int'(bus.busy), 0);
        chk("abort win_on_rst", int'(bus.win), 0);
        chk("abort done_on_rst", int'(bus.done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort idle_after", int'(bus.busy), 0);

        // Out-of-range pos and empty cell: done one edge after accept.
        clr_board(); put(44, 2'b10);
        issue(120, 1, 1'b0, 2'b00, "pos120");
        drain("pos120");
        issue(45, 1, 1'b0, 2'b00, "empty45");
        drain("empty45");
        put(45, 2'b01);
        issue(45, 1, 1'b0, 2'b00, "code01");
        drain("code01");

        // Isolated stone; board changed mid-scan must not matter.
        clr_board(); put(44, 2'b10);
        issue(44, 13, 1'b0, 2'b00, "iso44");
        for (int k = 40; k < 50; k++) put(k, 2'b10);
        bus.board_state = brd;
        drain("iso44");

        // Row wrap must not connect rows.
        clr_board();
        for (int k = 7; k < 12; k++) put(k, 2'b10);
        issue(9, 15, 1'b0, 2'b00, "rowwrap");
        drain("rowwrap");

        // Four in a row is not a win.
        clr_board();
        for (int k = 0; k < 4; k++) put(k, 2'b10);
        issue(0, 16, 1'b0, 2'b00, "four");
        drain("four");

        // Horizontal five.
        clr_board();
        for (int k = 0; k < 5; k++) put(k, 2'b10);
        issue(2, 8, 1'b1, 2'b10, "horiz5");
        drain("horiz5");

        // Sticky: white five afterwards still accepted, winner unchanged.
        clr_board();
        for (int k = 50; k < 55; k++) put(k, 2'b11);
        issue(52, 8, 1'b1, 2'b10, "sticky");
        drain("sticky");

        do_reset();
        chk("rst clears win", int'(bus.win), 0);
        chk("rst clears winner", int'(bus.winner), 0);

        // Anti-diagonal white five, found on the last direction.
        clr_board();
        put(4, 2'b11); put(13, 2'b11); put(22, 2'b11); put(31, 2'b11); put(40, 2'b11);
        issue(40, 16, 1'b1, 2'b11, "antidiag");
        drain("antidiag");

        do_reset();

        // Six in a row counts as a win.
        clr_board();
        for (int k = 0; k < 6; k++) put(k, 2'b10);
        issue(2, 9, 1'b1, 2'b10, "six");
        drain("six");

        // Vertical five, black.
        do_reset();
        clr_board();
        for (int r = 2; r < 7; r++) put(r * 10 + 3, 2'b10);
        // + : 73 empty (p=1); - : 53,43,33,23 (cap, n=4); H 3 cycles first.
        issue(63, 1 + 3 + 6, 1'b1, 2'b10, "vert5");
        drain("vert5");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
